bcd_down_counter: RTL and testbench

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

---
 rtl/bcd_down_counter_pkg.sv | 20 ++
 rtl/bcd_digit_down.sv | 28 ++
 rtl/bcd_down_counter.sv | 136 +++++++++++++
 tb/tb_bcd_down_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the BCD down counter: FSM state type, decade
// width, largest legal BCD digit and the nibble clamp helper.
package bcd_down_counter_pkg;

  localparam int DEC_W = 4;
  localparam logic [DEC_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Any nibble above 9 is forced to 9 so a decade never holds a non-BCD code.
  function automatic logic [DEC_W-1:0] clamp_nib(input logic [DEC_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down counter. Loads a (pre-clamped) nibble or
// decrements with 0 -> 9 wrap; borrow_out asks the next decade to decrement.
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             load,
  input  logic [DEC_W-1:0] load_nib,
  output logic [DEC_W-1:0] nibble,
  output logic             borrow_out
);

  // Decade register: load has priority over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nibble <= '0;
    end else if (load) begin
      nibble <= load_nib;
    end else if (dec_en) begin
      nibble <= (nibble == '0) ? BCD_MAX : nibble - 4'd1;
    end
  end

  assign borrow_out = (nibble == '0) && dec_en;

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD down counter with IDLE/RUN/PAUSED/DONE control.
// Optional feature macro: BCD_AUTO_RELOAD_EN -- keeps the last loaded value
// and reloads it when the countdown wraps past zero, staying in RUN.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  zero
);

  localparam int W = DEC_W * DIGITS;

  state_t          state, state_next;
  logic            dec;
  logic            done_next;
  logic            is_one;
  logic            digit_load;
  logic [W-1:0]    digit_src;
  logic [W-1:0]    load_clamped;
  logic [DIGITS-1:0] borrow;
  logic [DIGITS-1:0] dig_en;
  logic            unused_top_borrow;

`ifdef BCD_AUTO_RELOAD_EN
  logic            reload;
  logic [W-1:0]    reload_val;
`endif

  assign zero   = (count == '0);
  assign is_one = (count == W'(1));

  // Clamp every incoming decade before it reaches a register.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*DEC_W +: DEC_W] = clamp_nib(load_val[i*DEC_W +: DEC_W]);
    end
  end

  // Control state, registered running flag and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      done    <= done_next;
    end
  end

  // Next state and datapath strobes; priority load > pause > start > tick.
  always_comb begin
    state_next = state;
    dec        = 1'b0;
    done_next  = 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
    reload     = 1'b0;
`endif
    if (load) begin
      state_next = IDLE;
    end else if (pause && state == RUN) begin
      state_next = PAUSED;
    end else if (start && (state == IDLE || state == PAUSED)) begin
      state_next = zero ? DONE : RUN;
    end else if (tick && state == RUN) begin
`ifdef BCD_AUTO_RELOAD_EN
      // Zero is shown for one tick with done, then the stored value returns.
      if (zero) begin
        reload = 1'b1;
      end else begin
        dec       = 1'b1;
        done_next = is_one;
      end
`else
      dec = 1'b1;
      if (is_one) begin
        done_next  = 1'b1;
        state_next = DONE;
      end
`endif
    end
  end

`ifdef BCD_AUTO_RELOAD_EN
  // Remember the last clamped preset for automatic restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_val <= '0;
    end else if (load) begin
      reload_val <= load_clamped;
    end
  end

  assign digit_load = load | reload;
  assign digit_src  = load ? load_clamped : reload_val;
`else
  assign digit_load = load;
  assign digit_src  = load_clamped;
`endif

  // Decade chain: the lowest decade decrements on dec, each higher one on borrow.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_first
      assign dig_en[i] = dec;
    end else begin : g_next
      assign dig_en[i] = borrow[i-1];
    end

    bcd_digit_down u_digit (
      .clk        (clk),
      .rst        (rst),
      .dec_en     (dig_en[i]),
      .load       (digit_load),
      .load_nib   (digit_src[i*DEC_W +: DEC_W]),
      .nibble     (count[i*DEC_W +: DEC_W]),
      .borrow_out (borrow[i])
    );
  end

  // The top decade never borrows while counting (RUN never decrements zero).
  assign unused_top_borrow = borrow[DIGITS-1];

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS = 2). Covers both the
// default build and the BCD_AUTO_RELOAD_EN build.
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, start, pause, tick;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       running, done, zero;

  int checks = 0;
  int passed = 0;

  // Reference model: decimal value, abstract state, done pulse, stored preset.
  int m_val, m_st, m_store;
  bit m_done;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .count    (count),
    .running  (running),
    .done     (done),
    .zero     (zero)
  );

  function automatic int clamp_dec(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_val   = 0;
    m_st    = M_IDLE;
    m_done  = 1'b0;
    m_store = 0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle 1 ns.
  task automatic step(input bit l, input logic [7:0] lv, input bit s,
                      input bit p, input bit t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    m_done = 1'b0;
    if (l) begin
      m_val   = clamp_dec(lv);
      m_store = m_val;
      m_st    = M_IDLE;
    end else if (p && m_st == M_RUN) begin
      m_st = M_PAUSED;
    end else if (s && (m_st == M_IDLE || m_st == M_PAUSED)) begin
      m_st = (m_val == 0) ? M_DONE : M_RUN;
    end else if (t && m_st == M_RUN) begin
`ifdef BCD_AUTO_RELOAD_EN
      if (m_val == 0) begin
        m_val = m_store;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) m_done = 1'b1;
      end
`else
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_done = 1'b1;
        m_st   = M_DONE;
      end
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    load = 0; start = 0; pause = 0; tick = 0; load_val = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++; if (count !== 8'h00) $display("FAIL reset_count: got %h expected 00", count); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero); else passed++;
    #10 rst = 1'b1;
  endtask

`ifndef BCD_AUTO_RELOAD_EN
  task automatic test_countdown();
    int exp;
    step(1, 8'h12, 0, 0, 0);
    checks++; if (count !== 8'h12) $display("FAIL cd_load: got %h expected 12", count); else passed++;
    step(0, 8'h00, 1, 0, 1);
    checks++; if ({count, running} !== {8'h12, 1'b1}) $display("FAIL cd_start: got %h/%b expected 12/1", count, running); else passed++;
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00, 0, 0, 1);
      exp = 11 - i;
      checks++;
      if ({count, done, running} !== {to_bcd(exp), exp == 0, exp != 0})
        $display("FAIL cd_step%0d: got %h/%b/%b expected %h/%b/%b", i, count, done, running,
                 to_bcd(exp), exp == 0, exp != 0);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, i == 1, 0, 1);
      checks++;
      if ({count, done, running} !== {8'h00, 1'b0, 1'b0})
        $display("FAIL cd_hold%0d: got %h/%b/%b expected 00/0/0", i, count, done, running);
      else passed++;
    end
  endtask
`endif

  task automatic test_clamp();
    step(1, 8'h3A, 0, 0, 0);
    checks++; if (count !== 8'h39) $display("FAIL clamp_load: got %h expected 39", count); else passed++;
    step(1, 8'hF7, 0, 0, 0);
    checks++; if (count !== 8'h97) $display("FAIL clamp_hi: got %h expected 97", count); else passed++;
    step(1, 8'h3A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    checks++; if (count !== 8'h38) $display("FAIL clamp_tick: got %h expected 38", count); else passed++;
  endtask

  task automatic test_pause();
    step(1, 8'h25, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1);
    checks++; if (count !== 8'h22) $display("FAIL pause_pre: got %h expected 22", count); else passed++;
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 1, 1);
      checks++;
      if ({count, running} !== {8'h22, 1'b0})
        $display("FAIL pause_hold%0d: got %h/%b expected 22/0", i, count, running);
      else passed++;
    end
    step(0, 8'h00, 1, 0, 1);
    checks++; if ({count, running} !== {8'h22, 1'b1}) $display("FAIL pause_resume: got %h/%b expected 22/1", count, running); else passed++;
    step(0, 8'h00, 0, 0, 1);
    checks++; if (count !== 8'h21) $display("FAIL pause_next: got %h expected 21", count); else passed++;
  endtask

  task automatic test_async_reset();
    step(1, 8'h50, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1);
    checks++; if (count !== 8'h47) $display("FAIL arst_pre: got %h expected 47", count); else passed++;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL arst_now: got %h/%b/%b expected 00/0/0", count, running, done);
    else passed++;
    model_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 0, 1);
      checks++;
      if ({count, running} !== {8'h00, 1'b0})
        $display("FAIL arst_idle%0d: got %h/%b expected 00/0", i, count, running);
      else passed++;
    end
  endtask

  task automatic test_load_wins();
    step(1, 8'h05, 1, 0, 0);
    checks++; if ({count, running} !== {8'h05, 1'b0}) $display("FAIL lw_load: got %h/%b expected 05/0", count, running); else passed++;
    step(1, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if ({count, running, done} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL lw_zero_start: got %h/%b/%b expected 00/0/0", count, running, done);
    else passed++;
    step(0, 8'h00, 0, 0, 1);
    checks++; if (done !== 1'b0) $display("FAIL lw_no_done: got %b expected 0", done); else passed++;
  endtask

`ifdef BCD_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int seq[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    step(1, 8'h03, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 0, 0, 1);
      checks++;
      if ({count, done, running} !== {to_bcd(seq[i]), seq[i] == 0, 1'b1})
        $display("FAIL ar_step%0d: got %h/%b/%b expected %h/%b/1", i, count, done, running,
                 to_bcd(seq[i]), seq[i] == 0);
      else passed++;
    end
  endtask
`endif

  task automatic test_random();
    bit l, s, p, t;
    int op;
    logic [7:0] lv;
    for (int i = 0; i < 600; i++) begin
      l  = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h15)) : 8'($urandom);
      op = $urandom_range(0, 9);
      p  = (op < 2);
      s  = (op >= 2 && op < 4 && m_st != M_RUN);
      t  = ($urandom_range(0, 3) != 0);
      step(l, lv, s, p, t);
      checks++;
      if ({count, running, done, zero} !== {to_bcd(m_val), m_st == M_RUN, m_done, m_val == 0})
        $display("FAIL rand%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", i, count, running, done, zero,
                 to_bcd(m_val), m_st == M_RUN, m_done, m_val == 0);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
`ifndef BCD_AUTO_RELOAD_EN
    test_countdown();
`else
    test_auto_reload();
`endif
    test_clamp();
    test_pause();
    test_async_reset();
    test_load_wins();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
